// File: rtl/cal_pkg.sv
// Shared types and defaults for the comparator offset calibration engine.
package cal_pkg;

    // Default trim magnitude width
    localparam int TRIM_W_DEF = 5;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETTLE = 3'd1,
        SAMPLE = 3'd2,
        DECIDE = 3'd3,
        DONE   = 3'd4
    } cal_state_t;

    typedef enum logic {
        LEFT  = 1'b0,
        RIGHT = 1'b1
    } side_t;

endpackage

// File: rtl/cal_sample_acc.sv
// Sample accumulator: 2-FF synchroniser on the asynchronous comparator
// output, a ones counter enabled during sampling, and the majority compare.
// A tie (count == N/2) resolves to 0.
module cal_sample_acc #(
    parameter int AVG_LOG2 = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    input  logic cap_out,
    output logic majority
);

    localparam int                N_SAMP = 1 << AVG_LOG2;
    localparam int                CNT_W  = AVG_LOG2 + 1;
    localparam logic [CNT_W-1:0]  HALF   = CNT_W'(N_SAMP / 2);

    logic             sync1_q;
    logic             sync2_q;
    logic [CNT_W-1:0] cnt_q;

    // Two-flop synchroniser bringing cap_out into the clk domain
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= cap_out;
            sync2_q <= sync1_q;
        end
    end

    // Count synchronised ones while sampling; cleared ahead of each window
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (en && sync2_q) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end else begin
            cnt_q <= cnt_q;
        end
    end

    assign majority = (cnt_q > HALF);

endmodule

// File: rtl/comparator_offset_cal.sv
// Closed-loop offset calibration for one flash-ADC comparator: a sign
// decision with trims at zero, then a TRIM_W-bit SAR on the magnitude of the
// selected side. Optional feature macro: CAL_OVERRIDE_EN (adds ovr_en /
// ovr_code for a direct, registered trim override).
module comparator_offset_cal
    import cal_pkg::*;
#(
    parameter int TRIM_W     = TRIM_W_DEF,
    parameter int AVG_LOG2   = 3,
    parameter int SETTLE_CYC = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cal_start,
    input  logic              cap_out,
    output logic [TRIM_W-1:0] b_left,
    output logic [TRIM_W-1:0] b_right,
    output logic              cal_busy,
    output logic              cal_done,
    output logic              cal_sat
`ifdef CAL_OVERRIDE_EN
    ,
    input  logic              ovr_en,
    input  logic signed [TRIM_W:0] ovr_code
`endif
);

    localparam int N_SAMP  = 1 << AVG_LOG2;
    localparam int SEQ_MAX = (SETTLE_CYC > N_SAMP) ? SETTLE_CYC : N_SAMP;
    localparam int CNT_W   = $clog2(SEQ_MAX) + 1;
    localparam int BIT_W   = $clog2(TRIM_W + 1);
    localparam logic [CNT_W-1:0]  SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0]  SAMPLE_LAST = CNT_W'(N_SAMP - 1);
    localparam logic [TRIM_W-1:0] MSB_MASK    = TRIM_W'(1) << (TRIM_W - 1);

    generate
        if (SETTLE_CYC < 2) begin : g_bad_settle
            $error("SETTLE_CYC must be at least 2 to cover the input synchroniser");
        end
    endgenerate

    cal_state_t        state_q;
    side_t             side_q;
    logic              pol_q;
    logic              sign_step_q;
    logic [BIT_W-1:0]  bit_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [TRIM_W-1:0] b_left_q;
    logic [TRIM_W-1:0] b_right_q;
    logic              busy_q;
    logic              done_q;
    logic              sat_q;

    logic              acc_clr_s;
    logic              acc_en_s;
    logic              majority_s;
    logic [TRIM_W-1:0] sel_mag_s;
    logic [TRIM_W-1:0] bit_mask_s;
    logic [TRIM_W-1:0] kept_mag_s;
    logic [TRIM_W-1:0] next_mag_s;

    cal_sample_acc #(
        .AVG_LOG2 (AVG_LOG2)
    ) u_acc (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (acc_clr_s),
        .en       (acc_en_s),
        .cap_out  (cap_out),
        .majority (majority_s)
    );

    // Accumulator control: clear while settling, count while sampling
    always_comb begin
        acc_clr_s = (state_q == SETTLE);
        acc_en_s  = (state_q == SAMPLE);
    end

    // SAR arithmetic on the selected side: resolve the trial bit, then arm the next one
    always_comb begin
        sel_mag_s  = (side_q == LEFT) ? b_left_q : b_right_q;
        bit_mask_s = TRIM_W'(1) << bit_q;
        kept_mag_s = (majority_s == pol_q) ? sel_mag_s : (sel_mag_s & ~bit_mask_s);
        next_mag_s = (bit_q == BIT_W'(0)) ? kept_mag_s : (kept_mag_s | (bit_mask_s >> 1));
    end

`ifdef CAL_OVERRIDE_EN
    logic signed [TRIM_W:0] ovr_neg_s;
    logic [TRIM_W-1:0]      ovr_left_s;
    logic [TRIM_W-1:0]      ovr_right_s;

    // Override decode; negating the most-negative code overflows, so saturate it
    always_comb begin
        ovr_neg_s   = -ovr_code;
        ovr_left_s  = ovr_code[TRIM_W] ? (ovr_neg_s[TRIM_W] ? {TRIM_W{1'b1}} : ovr_neg_s[TRIM_W-1:0])
                                       : {TRIM_W{1'b0}};
        ovr_right_s = (!ovr_code[TRIM_W] && (ovr_code != '0)) ? ovr_code[TRIM_W-1:0]
                                                              : {TRIM_W{1'b0}};
    end
`endif

    // Calibration FSM with settle/sample sequencing and registered outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            side_q      <= LEFT;
            pol_q       <= 1'b0;
            sign_step_q <= 1'b0;
            bit_q       <= '0;
            cnt_q       <= '0;
            b_left_q    <= '0;
            b_right_q   <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            sat_q       <= 1'b0;
`ifdef CAL_OVERRIDE_EN
        end else if (ovr_en) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            sat_q       <= 1'b0;
            b_left_q    <= ovr_left_s;
            b_right_q   <= ovr_right_s;
`endif
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (cal_start) begin
                        state_q     <= SETTLE;
                        cnt_q       <= '0;
                        sign_step_q <= 1'b1;
                        b_left_q    <= '0;
                        b_right_q   <= '0;
                        busy_q      <= 1'b1;
                        done_q      <= 1'b0;
                        sat_q       <= 1'b0;
                    end else if (state_q == IDLE) begin
                        // Idle always presents neutral trims (e.g. after override release)
                        b_left_q    <= '0;
                        b_right_q   <= '0;
                    end else begin
                        state_q     <= DONE;
                    end
                end
                SETTLE: begin
                    if (cnt_q == SETTLE_LAST) begin
                        state_q <= SAMPLE;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q   <= cnt_q + CNT_W'(1);
                    end
                end
                SAMPLE: begin
                    if (cnt_q == SAMPLE_LAST) begin
                        state_q <= DECIDE;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q   <= cnt_q + CNT_W'(1);
                    end
                end
                DECIDE: begin
                    if (sign_step_q) begin
                        // Sign step: a high majority means positive offset, trim on the left
                        sign_step_q <= 1'b0;
                        pol_q       <= majority_s;
                        side_q      <= majority_s ? LEFT : RIGHT;
                        bit_q       <= BIT_W'(TRIM_W - 1);
                        b_left_q    <= majority_s ? MSB_MASK : {TRIM_W{1'b0}};
                        b_right_q   <= majority_s ? {TRIM_W{1'b0}} : MSB_MASK;
                        state_q     <= SETTLE;
                    end else begin
                        if (side_q == LEFT) begin
                            b_left_q  <= next_mag_s;
                        end else begin
                            b_right_q <= next_mag_s;
                        end
                        if (bit_q == BIT_W'(0)) begin
                            state_q <= DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            sat_q   <= &kept_mag_s;
                        end else begin
                            bit_q   <= bit_q - BIT_W'(1);
                            state_q <= SETTLE;
                        end
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    b_left_q  <= '0;
                    b_right_q <= '0;
                    busy_q    <= 1'b0;
                    done_q    <= 1'b0;
                    sat_q     <= 1'b0;
                end
            endcase
        end
    end

    assign b_left   = b_left_q;
    assign b_right  = b_right_q;
    assign cal_busy = busy_q;
    assign cal_done = done_q;
    assign cal_sat  = sat_q;

endmodule

// File: tb/tb_comparator_offset_cal.sv
// Directed bench for comparator_offset_cal with a behavioural comparator
// (eff = offset + b_right - b_left; cap_out = eff > 0) and a scoreboard of
// expected calibration results. CAL_OVERRIDE_EN enables the override steps.
module tb_comparator_offset_cal;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cal_start = 1'b0;
    logic       cap_out;
    logic [4:0] b_left;
    logic [4:0] b_right;
    logic       cal_busy;
    logic       cal_done;
    logic       cal_sat;
`ifdef CAL_OVERRIDE_EN
    logic              ovr_en = 1'b0;
    logic signed [5:0] ovr_code = 6'sd0;
`endif

    int   offset = 0;
    bit   alt_mode = 1'b0;
    logic alt_q = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;

    typedef struct {
        int bl;
        int br;
        int sat;
        int lat;
    } exp_t;
    exp_t sb_q[$];

    always #5 clk = ~clk;

    // Alternating comparator pattern, changes away from the sampling edge
    always @(negedge clk) alt_q <= ~alt_q;

    // Behavioural comparator with inputs shorted
    always_comb begin
        cap_out = alt_mode ? alt_q : ((offset + int'(b_right) - int'(b_left)) > 0);
    end

    comparator_offset_cal #(
        .TRIM_W     (5),
        .AVG_LOG2   (3),
        .SETTLE_CYC (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cal_start (cal_start),
        .cap_out   (cap_out),
        .b_left    (b_left),
        .b_right   (b_right),
        .cal_busy  (cal_busy),
        .cal_done  (cal_done),
        .cal_sat   (cal_sat)
`ifdef CAL_OVERRIDE_EN
        ,
        .ovr_en    (ovr_en),
        .ovr_code  (ovr_code)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Start a calibration, optionally pulse start again while busy, wait for done
    task automatic run_cal(input string tag, input int bl, input int br, input int sat,
                           input int busy_pulse_cyc);
        exp_t e;
        int   cyc;
        e = '{bl, br, sat, 79};
        sb_q.push_back(e);
        @(posedge clk); #1 cal_start = 1'b1;
        @(posedge clk); #1 cal_start = 1'b0;
        cyc = 1;
        check({tag, "/busy_on"}, 32'(cal_busy), 32'd1);
        check({tag, "/done_clr"}, 32'(cal_done), 32'd0);
        check({tag, "/trims_clr"}, 32'({b_left, b_right}), 32'd0);
        while (cal_done !== 1'b1 && cyc < 200) begin
            cal_start = (cyc == busy_pulse_cyc);
            @(posedge clk); #1;
            cyc++;
            check({tag, "/one_side"}, 32'((b_left == 5'd0) || (b_right == 5'd0)), 32'd1);
        end
        cal_start = 1'b0;
        e = sb_q.pop_front();
        check({tag, "/latency"}, 32'(cyc), 32'(e.lat));
        check({tag, "/b_left"}, 32'(b_left), 32'(e.bl));
        check({tag, "/b_right"}, 32'(b_right), 32'(e.br));
        check({tag, "/sat"}, 32'(cal_sat), 32'(e.sat));
        check({tag, "/busy_off"}, 32'(cal_busy), 32'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "/b_left"}, 32'(b_left), 32'd0);
        check({tag, "/b_right"}, 32'(b_right), 32'd0);
        check({tag, "/busy"}, 32'(cal_busy), 32'd0);
        check({tag, "/done"}, 32'(cal_done), 32'd0);
        check({tag, "/sat"}, 32'(cal_sat), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst_n = 1'b1;

        // Positive, negative, saturating and zero offsets
        offset = 7;
        run_cal("off_p7", 6, 0, 0, 0);
        offset = -5;
        run_cal("off_m5", 0, 5, 0, 0);
        offset = 40;
        run_cal("off_p40", 31, 0, 1, 0);
        offset = 0;
        run_cal("off_0", 0, 0, 0, 0);

        // 4-of-8 ties resolve to 0: right side, every trial bit kept
        alt_mode = 1'b1;
        run_cal("alt", 0, 31, 1, 0);
        alt_mode = 1'b0;

        // Start while busy is ignored; completion time unchanged
        offset = 7;
        run_cal("busy_start", 6, 0, 0, 20);

        // Reset during SAR step 3 aborts; start held during reset is ignored
        @(posedge clk); #1 cal_start = 1'b1;
        @(posedge clk); #1 cal_start = 1'b0;
        repeat (44) @(posedge clk);
        #1;
        check("mid_search/b_left", 32'(b_left), 32'd4);
        check("mid_search/busy", 32'(cal_busy), 32'd1);
        rst_n = 1'b0;
        cal_start = 1'b1;
        @(posedge clk); #1;
        check_all_zero("abort");
        @(posedge clk); #1;
        rst_n = 1'b1;
        cal_start = 1'b0;
        @(posedge clk); #1;
        check_all_zero("post_abort");

        // Recovery after abort
        offset = -5;
        run_cal("recover", 0, 5, 0, 0);

`ifdef CAL_OVERRIDE_EN
        // Direct trim override
        @(posedge clk); #1;
        ovr_en = 1'b1;
        ovr_code = -6'sd9;
        @(posedge clk); #1;
        check("ovr_m9/b_left", 32'(b_left), 32'd9);
        check("ovr_m9/b_right", 32'(b_right), 32'd0);
        check("ovr_m9/busy", 32'(cal_busy), 32'd0);
        check("ovr_m9/done", 32'(cal_done), 32'd0);
        ovr_code = 6'sd12;
        @(posedge clk); #1;
        check("ovr_p12/b_right", 32'(b_right), 32'd12);
        check("ovr_p12/b_left", 32'(b_left), 32'd0);
        ovr_code = -6'sd32;
        @(posedge clk); #1;
        check("ovr_min/b_left", 32'(b_left), 32'd31);
        ovr_en = 1'b0;
        @(posedge clk); #1;
        check_all_zero("ovr_off");
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
